// File: rtl/axis_mon_pkg.sv
// Shared types for the AXI-Stream packet monitor: error bit positions,
// monitor FSM states and the per-packet error record.
package axis_mon_pkg;

   localparam int ERR_PROTO   = 3;
   localparam int ERR_RUNT    = 2;
   localparam int ERR_OVERLEN = 1;
   localparam int ERR_SAT     = 0;

   typedef enum logic [1:0] {IDLE, BODY, OVER} mon_state_t;

   // Field order matches the ERR_* positions when packed onto o_stat_err.
   typedef struct packed {
      logic proto;
      logic runt;
      logic overlen;
      logic sat;
   } stat_err_t;

endpackage

// File: rtl/axis_skid.sv
// Registered skid stage: one output register plus one skid register, with a
// registered ready so the upstream path has no combinational dependency.
module axis_skid #(
   parameter int PW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          s_valid,
   output logic          s_ready,
   input  logic [PW-1:0] s_data,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [PW-1:0] m_data
);

   logic          skid_valid;
   logic [PW-1:0] skid_data;
   logic          acc;

   assign acc = s_valid && s_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         s_ready    <= 1'b0;
         m_valid    <= 1'b0;
         m_data     <= '0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
      end else if (m_valid && !m_ready) begin
         // Output held: a new beat can only park in the skid register.
         if (acc) begin
            skid_valid <= 1'b1;
            skid_data  <= s_data;
         end
         s_ready <= !(skid_valid || acc);
      end else if (skid_valid) begin
         m_valid    <= 1'b1;
         m_data     <= skid_data;
         skid_valid <= 1'b0;
         s_ready    <= 1'b1;
      end else begin
         m_valid <= acc;
         if (acc) m_data <= s_data;
         s_ready <= 1'b1;
      end
   end

endmodule

// File: rtl/axis_pkt_monitor.sv
// AXI-Stream pass-through that measures packet length, flags upstream protocol
// faults and posts one status record per packet. AXIS_PKT_STALL_WD_EN adds a
// downstream stall watchdog on o_stall_err.
module axis_pkt_monitor
   import axis_mon_pkg::*;
#(
   parameter int DW         = 32,
   parameter int UW         = 1,
   parameter int LGLEN      = 16,
   parameter int MAX_PACKET = 1514,
   parameter int MIN_PACKET = 0,
   parameter int MAX_STALL  = 64
) (
   input  logic             i_aclk,
   input  logic             i_reset,
   input  logic             S_AXIS_TVALID,
   output logic             S_AXIS_TREADY,
   input  logic [DW-1:0]    S_AXIS_TDATA,
   input  logic [DW/8-1:0]  S_AXIS_TKEEP,
   input  logic [DW/8-1:0]  S_AXIS_TSTRB,
   input  logic             S_AXIS_TLAST,
   input  logic [UW-1:0]    S_AXIS_TUSER,
   output logic             M_AXIS_TVALID,
   input  logic             M_AXIS_TREADY,
   output logic [DW-1:0]    M_AXIS_TDATA,
   output logic [DW/8-1:0]  M_AXIS_TKEEP,
   output logic [DW/8-1:0]  M_AXIS_TSTRB,
   output logic             M_AXIS_TLAST,
   output logic [UW-1:0]    M_AXIS_TUSER,
   output logic             o_stat_valid,
   input  logic             i_stat_ready,
   output logic [LGLEN-1:0] o_stat_len,
   output logic [3:0]       o_stat_err,
   output logic             o_stat_lost,
   output logic             o_stall_err
);

   localparam int KW  = DW / 8;
   localparam int PW  = DW + 2 * KW + 1 + UW;
   localparam int VBW = $clog2(KW + 1);

   logic [PW-1:0] m_pay;

   axis_skid #(.PW(PW)) u_skid (
      .clk     (i_aclk),
      .rst     (i_reset),
      .s_valid (S_AXIS_TVALID),
      .s_ready (S_AXIS_TREADY),
      .s_data  ({S_AXIS_TDATA, S_AXIS_TKEEP, S_AXIS_TSTRB, S_AXIS_TLAST, S_AXIS_TUSER}),
      .m_valid (M_AXIS_TVALID),
      .m_ready (M_AXIS_TREADY),
      .m_data  (m_pay)
   );

   assign {M_AXIS_TDATA, M_AXIS_TKEEP, M_AXIS_TSTRB, M_AXIS_TLAST, M_AXIS_TUSER} = m_pay;

   mon_state_t       state;
   logic [LGLEN-1:0] cnt, new_cnt;
   logic [LGLEN:0]   sum;
   logic [VBW-1:0]   vb;
   logic             acc, emit, sat_evt, ovf, runt;
   logic             sat_flag, proto_flag, proto_now, strb_bad, unstable;
   stat_err_t        err_nxt, stat_err;

   logic             prev_stall, prev_last;
   logic [UW-1:0]    prev_user;
   logic [KW-1:0]    prev_keep, prev_strb;
   logic [DW-1:0]    prev_data, dmask;

   assign acc     = S_AXIS_TVALID && S_AXIS_TREADY;
   assign emit    = acc && S_AXIS_TLAST;
   assign vb      = VBW'($countones(S_AXIS_TKEEP & S_AXIS_TSTRB));
   assign sum     = {1'b0, cnt} + (LGLEN+1)'(vb);
   assign sat_evt = sum[LGLEN];
   assign new_cnt = sat_evt ? '1 : sum[LGLEN-1:0];
   assign ovf     = (MAX_PACKET != 0) && (32'(sum) > 32'(MAX_PACKET));
   assign runt    = (MIN_PACKET != 0) && (32'(new_cnt) < 32'(MIN_PACKET));

   // Only data bytes the stalled beat marked as kept must hold steady.
   always_comb begin
      dmask = '0;
      for (int i = 0; i < KW; i++) dmask[8*i +: 8] = {8{prev_keep[i]}};
   end

   assign strb_bad  = S_AXIS_TVALID && |(S_AXIS_TSTRB & ~S_AXIS_TKEEP);
   assign unstable  = prev_stall && (!S_AXIS_TVALID || S_AXIS_TLAST != prev_last ||
                      S_AXIS_TUSER != prev_user || S_AXIS_TKEEP != prev_keep ||
                      S_AXIS_TSTRB != prev_strb || |((S_AXIS_TDATA ^ prev_data) & dmask));
   assign proto_now = strb_bad || unstable;

   always_comb begin
      err_nxt         = '0;
      err_nxt.proto   = proto_flag || proto_now;
      err_nxt.runt    = runt;
      err_nxt.overlen = (state == OVER) || ovf;
      err_nxt.sat     = sat_flag || sat_evt;
   end

   // Reset clears the history, so the stability check is idle for one cycle.
   always_ff @(posedge i_aclk) begin
      if (i_reset) begin
         prev_stall <= 1'b0;
         prev_last  <= 1'b0;
         prev_user  <= '0;
         prev_keep  <= '0;
         prev_strb  <= '0;
         prev_data  <= '0;
      end else begin
         prev_stall <= S_AXIS_TVALID && !S_AXIS_TREADY;
         prev_last  <= S_AXIS_TLAST;
         prev_user  <= S_AXIS_TUSER;
         prev_keep  <= S_AXIS_TKEEP;
         prev_strb  <= S_AXIS_TSTRB;
         prev_data  <= S_AXIS_TDATA;
      end
   end

   always_ff @(posedge i_aclk) begin
      if (i_reset) begin
         state        <= IDLE;
         cnt          <= '0;
         sat_flag     <= 1'b0;
         proto_flag   <= 1'b0;
         o_stat_valid <= 1'b0;
         o_stat_len   <= '0;
         stat_err     <= '0;
         o_stat_lost  <= 1'b0;
      end else begin
         proto_flag <= emit ? 1'b0 : (proto_flag || proto_now);
         if (acc) begin
            if (S_AXIS_TLAST) begin
               state    <= IDLE;
               cnt      <= '0;
               sat_flag <= 1'b0;
            end else begin
               cnt      <= new_cnt;
               sat_flag <= sat_flag || sat_evt;
               if (ovf)                state <= OVER;
               else if (state == IDLE) state <= BODY;
            end
         end
         if (emit) begin
            if (o_stat_valid && !i_stat_ready) begin
               o_stat_lost <= 1'b1;
            end else begin
               o_stat_valid <= 1'b1;
               o_stat_len   <= new_cnt;
               stat_err     <= err_nxt;
            end
         end else if (i_stat_ready) begin
            o_stat_valid <= 1'b0;
         end
      end
   end

   assign o_stat_err = stat_err;

`ifdef AXIS_PKT_STALL_WD_EN
   localparam int SW = $clog2(MAX_STALL + 1);
   logic [SW-1:0] stall_cnt;
   logic          stall_err;

   always_ff @(posedge i_aclk) begin
      if (i_reset) begin
         stall_cnt <= '0;
         stall_err <= 1'b0;
      end else begin
         if (M_AXIS_TVALID && !M_AXIS_TREADY) begin
            if (stall_cnt != SW'(MAX_STALL)) stall_cnt <= stall_cnt + SW'(1);
         end else begin
            stall_cnt <= '0;
         end
         if (stall_cnt == SW'(MAX_STALL)) stall_err <= 1'b1;
      end
   end

   assign o_stall_err = stall_err;
`else
   assign o_stall_err = 1'b0;
`endif

endmodule

// File: tb/tb_axis_pkt_monitor.sv
// Directed bench for axis_pkt_monitor: a default instance plus a small
// instance (MAX_PACKET=8, MIN_PACKET=2, LGLEN=4) driven by the same stream.
module tb_axis_pkt_monitor;
   import axis_mon_pkg::*;

   localparam logic [3:0] E_PROTO = 4'(1 << ERR_PROTO);
   localparam logic [3:0] E_RUNT  = 4'(1 << ERR_RUNT);
   localparam logic [3:0] E_OVER  = 4'(1 << ERR_OVERLEN);
   localparam logic [3:0] E_SAT   = 4'(1 << ERR_SAT);

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   always #5 clk = ~clk;

   logic        s_valid, s_last, m_ready, stat_ready;
   logic [31:0] s_data;
   logic [3:0]  s_keep, s_strb;
   logic [0:0]  s_user;

   logic        s_ready, m_valid, m_last, stat_valid, stat_lost, stall_err;
   logic [31:0] m_data;
   logic [3:0]  m_keep, m_strb, stat_err;
   logic [0:0]  m_user;
   logic [15:0] stat_len;

   logic        s_ready8, m_valid8, m_last8, stat_valid8, stat_lost8, stall_err8;
   logic [31:0] m_data8;
   logic [3:0]  m_keep8, m_strb8, stat_err8, stat_len8;
   logic [0:0]  m_user8;

   axis_pkt_monitor dut (
      .i_aclk(clk), .i_reset(rst),
      .S_AXIS_TVALID(s_valid), .S_AXIS_TREADY(s_ready), .S_AXIS_TDATA(s_data),
      .S_AXIS_TKEEP(s_keep), .S_AXIS_TSTRB(s_strb), .S_AXIS_TLAST(s_last), .S_AXIS_TUSER(s_user),
      .M_AXIS_TVALID(m_valid), .M_AXIS_TREADY(m_ready), .M_AXIS_TDATA(m_data),
      .M_AXIS_TKEEP(m_keep), .M_AXIS_TSTRB(m_strb), .M_AXIS_TLAST(m_last), .M_AXIS_TUSER(m_user),
      .o_stat_valid(stat_valid), .i_stat_ready(stat_ready), .o_stat_len(stat_len),
      .o_stat_err(stat_err), .o_stat_lost(stat_lost), .o_stall_err(stall_err)
   );

   axis_pkt_monitor #(.MAX_PACKET(8), .MIN_PACKET(2), .LGLEN(4)) dut8 (
      .i_aclk(clk), .i_reset(rst),
      .S_AXIS_TVALID(s_valid), .S_AXIS_TREADY(s_ready8), .S_AXIS_TDATA(s_data),
      .S_AXIS_TKEEP(s_keep), .S_AXIS_TSTRB(s_strb), .S_AXIS_TLAST(s_last), .S_AXIS_TUSER(s_user),
      .M_AXIS_TVALID(m_valid8), .M_AXIS_TREADY(m_ready), .M_AXIS_TDATA(m_data8),
      .M_AXIS_TKEEP(m_keep8), .M_AXIS_TSTRB(m_strb8), .M_AXIS_TLAST(m_last8), .M_AXIS_TUSER(m_user8),
      .o_stat_valid(stat_valid8), .i_stat_ready(stat_ready), .o_stat_len(stat_len8),
      .o_stat_err(stat_err8), .o_stat_lost(stat_lost8), .o_stall_err(stall_err8)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int acc_cnt = 0;
   bit lat_chk = 1'b0;
   logic [31:0] in_d[$];
   int          in_c[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: every accepted beat must come out once, in order.
   always @(negedge clk) begin
      if (rst) begin
         in_d.delete();
         in_c.delete();
      end else begin
         if (s_valid && s_ready) begin
            in_d.push_back(s_data);
            in_c.push_back(cyc);
            acc_cnt++;
         end
         if (m_valid && m_ready) begin
            if (in_d.size() == 0) chk("sb_extra_beat", in_d.size(), 1);
            else begin
               chk("sb_data", m_data, in_d.pop_front());
               if (lat_chk) chk("latency", cyc - in_c.pop_front(), 1);
               else void'(in_c.pop_front());
            end
         end
      end
   end

   task automatic put(input logic [31:0] d, input logic [3:0] k, input logic [3:0] s,
                      input logic l, input logic u);
      s_valid = 1'b1; s_data = d; s_keep = k; s_strb = s; s_last = l; s_user = u;
   endtask

   task automatic wait_acc();
      int n = 0;
      @(negedge clk);
      while (!s_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("accept", s_ready, 1);
      @(posedge clk); #1;
      s_valid = 1'b0;
   endtask

   task automatic send(input logic [31:0] d, input logic [3:0] k, input logic [3:0] s,
                       input logic l, input logic u);
      put(d, k, s, l, u);
      wait_acc();
   endtask

   task automatic pop(input string tag, input logic [31:0] l, input logic [3:0] e,
                      input logic [31:0] l8, input logic [3:0] e8);
      int n = 0;
      @(negedge clk);
      while (!stat_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_valid"}, stat_valid, 1);
      chk({tag, "_len"}, stat_len, l);
      chk({tag, "_err"}, stat_err, e);
      chk({tag, "_valid8"}, stat_valid8, 1);
      chk({tag, "_len8"}, stat_len8, l8);
      chk({tag, "_err8"}, stat_err8, e8);
      @(posedge clk); #1 stat_ready = 1'b1;
      @(posedge clk); #1 stat_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int base;
      s_valid = 0; s_data = 0; s_keep = 0; s_strb = 0; s_last = 0; s_user = 0;
      m_ready = 1; stat_ready = 0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_tready", s_ready, 0);
      chk("rst_mvalid", m_valid, 0);
      chk("rst_statvalid", stat_valid, 0);
      chk("rst_lost", stat_lost, 0);
      chk("rst_stall_err", stall_err, 0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("rel_tready", s_ready, 0);
      @(negedge clk);
      chk("post_tready", s_ready, 1);
      @(posedge clk); #1;

      // 4 full beats, 16 bytes; small instance goes over and saturates at 15
      lat_chk = 1'b1;
      for (int i = 0; i < 4; i++) send(32'h1000_0000 + i, 4'hF, 4'hF, i == 3, 1'b0);
      pop("t1", 16, 4'h0, 15, E_OVER | E_SAT);
      lat_chk = 1'b0;

      send(32'hAABB_CCDD, 4'h3, 4'h1, 1'b1, 1'b0);
      pop("t2a", 1, 4'h0, 1, E_RUNT);
      send(32'hAABB_CCDE, 4'h3, 4'h4, 1'b1, 1'b0);
      pop("t2b", 0, E_PROTO, 0, E_PROTO | E_RUNT);

      for (int i = 0; i < 3; i++) send(32'h3000_0000 + i, 4'hF, 4'hF, i == 2, 1'b0);
      pop("t3", 12, 4'h0, 12, E_OVER);

      // downstream stall: two beats fill the register pair, then ready drops
      m_ready = 1'b0;
      base = acc_cnt;
      fork
         begin
            for (int i = 0; i < 4; i++) send(32'h4000_0000 + i, 4'hF, 4'hF, i == 3, 1'b0);
         end
         begin
            repeat (3) @(negedge clk);
            chk("t4_mvalid", m_valid, 1);
            chk("t4_hold0", m_data, 32'h4000_0000);
            repeat (2) @(negedge clk);
            chk("t4_tready", s_ready, 0);
            chk("t4_acc", acc_cnt - base, 2);
            chk("t4_hold1", m_data, 32'h4000_0000);
            @(posedge clk); #1 m_ready = 1'b1;
         end
      join
      pop("t4", 16, 4'h0, 15, E_OVER | E_SAT);

      // TUSER changes while the beat is stalled
      m_ready = 1'b0;
      send(32'h5000_0000, 4'hF, 4'hF, 1'b0, 1'b0);
      send(32'h5000_0001, 4'hF, 4'hF, 1'b0, 1'b0);
      put(32'h5000_0002, 4'hF, 4'hF, 1'b1, 1'b0);
      @(posedge clk); #1 s_user = 1'b1;
      @(posedge clk); #1 m_ready = 1'b1;
      wait_acc();
      s_user = 1'b0;
      pop("t5", 12, E_PROTO, 12, E_PROTO | E_OVER);

      // status slot overflow, then reset mid-packet
      send(32'h6000_0000, 4'hF, 4'hF, 1'b1, 1'b0);
      send(32'h6000_0001, 4'h1, 4'h1, 1'b1, 1'b0);
      repeat (2) @(negedge clk);
      chk("t6_valid", stat_valid, 1);
      chk("t6_len_first", stat_len, 4);
      chk("t6_lost", stat_lost, 1);
      chk("t6_lost8", stat_lost8, 1);
      @(posedge clk); #1;
      send(32'h6100_0000, 4'hF, 4'hF, 1'b0, 1'b0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("t6_rst_valid", stat_valid, 0);
      chk("t6_rst_lost", stat_lost, 0);
      chk("t6_rst_mvalid", m_valid, 0);
      @(posedge clk); #1 rst = 1'b0;
      send(32'h6200_0000, 4'hF, 4'hF, 1'b1, 1'b0);
      pop("t6_new", 4, 4'h0, 4, 4'h0);

      repeat (3) @(negedge clk);
      chk("sb_drain", in_d.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
